a78_game_loader: RTL and testbench

// Streams an .a78 cartridge image from the SD card into PSRAM, then raises game_loaded so the bus front-end serves reads from PSRAM.

---
 rtl/a78_game_loader.sv | 275 +++++++++++++++++++++++++++
 tb/tb_a78_game_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a78_game_loader.sv
// Purpose: stream an .a78 image from the SD byte source into PSRAM, with the image's last byte placed at $FFFF.
// Latency: a payload byte is pushed on its strobe cycle; a PSRAM write request starts one cycle after the FIFO head is available.
// Backpressure: one PSRAM write is in flight at a time; the SD side is never stalled, so a push into a full FIFO raises error.
module a78_game_loader #(
  parameter int HEADER_BYTES  = 128,
  parameter int MAX_ROM_BYTES = 49152,
  parameter int MAX_SECTORS   = 97,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] start_sector_i,
  input  logic        sd_ready_i,
  output logic        sd_rd_o,
  output logic [31:0] sd_address_o,
  input  logic [7:0]  sd_dout_i,
  input  logic        sd_byte_available_i,
  output logic        psram_write_req_o,
  output logic [21:0] psram_addr_o,
  output logic [7:0]  psram_wdata_o,
  input  logic        psram_busy_i,
  output logic        loader_busy_o,
  output logic        game_loaded_o,
  output logic        error_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(MAX_SECTORS + 1);
  localparam logic [16:0]   HDR_OFF  = 17'(HEADER_BYTES);
  localparam logic [31:0]   MAX_SIZE = 32'(MAX_ROM_BYTES);
  localparam logic [SW-1:0] LAST_SEC = SW'(MAX_SECTORS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_RECV, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   start_sec_q, start_sec_d;
  logic [SW-1:0] sector_idx_q, sector_idx_d;
  logic [16:0]   offset_q, offset_d;
  logic [16:0]   written_q, written_d;
  logic [31:0]   rom_size_q, rom_size_d;
  logic          hdr_bad_q, hdr_bad_d;
  logic          busy_q, busy_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;

  logic          avail_prev_q;
  logic          byte_stb;
  logic          busy_s1_q, busy_s2_q;
  logic [7:0]    sig_byte;
  logic          size_ok;
  logic          push, flush, fail;
  logic [15:0]   push_addr;

  logic [23:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_empty;
  logic          req_q, inflight_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          issue, pop;

  assign byte_stb   = sd_byte_available_i & ~avail_prev_q;
  assign size_ok    = (rom_size_q != 32'd0) && (rom_size_q <= MAX_SIZE);
  // The base is 0x10000 - size, which wraps cleanly in 16 bits for any accepted size.
  assign push_addr  = (16'h0000 - rom_size_q[15:0]) + written_q[15:0];
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign issue      = ~req_q & ~inflight_q & ~fifo_empty & ~flush;
  assign pop        = req_q & busy_s2_q & ~flush;

  // Expected signature character at header offsets 1..9 ("ATARI7800").
  always_comb begin
    sig_byte = 8'h00;
    case (offset_q[3:0])
      4'd1: sig_byte = "A";
      4'd2: sig_byte = "T";
      4'd3: sig_byte = "A";
      4'd4: sig_byte = "R";
      4'd5: sig_byte = "I";
      4'd6: sig_byte = "7";
      4'd7: sig_byte = "8";
      4'd8: sig_byte = "0";
      4'd9: sig_byte = "0";
      default: sig_byte = 8'h00;
    endcase
  end

  // Loader FSM: sector requests, header parsing, payload placement and completion.
  always_comb begin
    state_d      = state_q;
    start_sec_d  = start_sec_q;
    sector_idx_d = sector_idx_q;
    offset_d     = offset_q;
    written_d    = written_q;
    rom_size_d   = rom_size_q;
    hdr_bad_d    = hdr_bad_q;
    busy_d       = busy_q;
    loaded_d     = loaded_q;
    err_d        = err_q;
    push         = 1'b0;
    flush        = 1'b0;
    fail         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_WAIT_RDY;
          start_sec_d  = start_sector_i;
          sector_idx_d = '0;
          offset_d     = '0;
          written_d    = '0;
          rom_size_d   = '0;
          hdr_bad_d    = 1'b0;
          busy_d       = 1'b1;
          loaded_d     = 1'b0;
          err_d        = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (sd_ready_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!sd_ready_i) state_d = S_RECV;
      end
      S_RECV: begin
        if (byte_stb) begin
          offset_d = offset_q + 17'd1;
          if (offset_q >= 17'd1 && offset_q <= 17'd9 && sd_dout_i != sig_byte)
            hdr_bad_d = 1'b1;
          if (offset_q >= 17'd49 && offset_q <= 17'd52)
            rom_size_d = {rom_size_q[23:0], sd_dout_i};
          if (offset_q == HDR_OFF && !size_ok) begin
            fail = 1'b1;
          end else if (offset_q >= HDR_OFF && !hdr_bad_q && written_q < rom_size_q[16:0]) begin
            if (fifo_full) begin
              fail = 1'b1;
            end else begin
              push      = 1'b1;
              written_d = written_q + 17'd1;
            end
          end
          // A bad signature is only acted on once the whole sector has been consumed.
          if (!fail && offset_q[8:0] == 9'h1FF) begin
            if (hdr_bad_d) begin
              fail = 1'b1;
            end else if (written_d == rom_size_q[16:0]) begin
              state_d = S_DRAIN;
            end else if (sector_idx_q == LAST_SEC) begin
              fail = 1'b1;
            end else begin
              sector_idx_d = sector_idx_q + SW'(1);
              state_d      = S_WAIT_RDY;
            end
          end
          if (fail) state_d = S_ERROR;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && !req_q && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        loaded_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      S_ERROR: begin
        err_d    = 1'b1;
        loaded_d = 1'b0;
        busy_d   = 1'b0;
        flush    = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and loader bookkeeping registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      start_sec_q  <= '0;
      sector_idx_q <= '0;
      offset_q     <= '0;
      written_q    <= '0;
      rom_size_q   <= '0;
      hdr_bad_q    <= 1'b0;
      busy_q       <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      avail_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_sec_q  <= start_sec_d;
      sector_idx_q <= sector_idx_d;
      offset_q     <= offset_d;
      written_q    <= written_d;
      rom_size_q   <= rom_size_d;
      hdr_bad_q    <= hdr_bad_d;
      busy_q       <= busy_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      avail_prev_q <= sd_byte_available_i;
    end
  end

  // Two-flop synchronizer for the PSRAM busy flag from the fast domain.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= psram_busy_i;
      busy_s2_q <= busy_s1_q;
    end
  end

  // FIFO storage: {16-bit Atari address, data byte}.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {push_addr, sd_dout_i};
  end

  // FIFO pointers and occupancy; an error empties the FIFO.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // PSRAM writer: present the head, drop the request once busy is seen, wait for busy to clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_q      <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if (flush) begin
        req_q <= 1'b0;
      end else if (issue) begin
        req_q   <= 1'b1;
        addr_q  <= fifo_mem_q[rd_ptr_q][23:8];
        wdata_q <= fifo_mem_q[rd_ptr_q][7:0];
      end else if (pop) begin
        req_q <= 1'b0;
      end
      if (pop) inflight_q <= 1'b1;
      else if (inflight_q && !busy_s2_q) inflight_q <= 1'b0;
    end
  end

  assign sd_rd_o           = (state_q == S_ISSUE);
  assign sd_address_o      = start_sec_q + 32'(sector_idx_q);
  assign psram_write_req_o = req_q;
  assign psram_addr_o      = {6'b0, addr_q};
  assign psram_wdata_o     = wdata_q;
  assign loader_busy_o     = busy_q;
  assign game_loaded_o     = loaded_q;
  assign error_o           = err_q;

endmodule

// File: tb/tb_a78_game_loader.sv
// Bench for a78_game_loader: random .a78 images streamed by an SD model, PSRAM writes checked
// against a queue of expected {address, data} built from the image with plain arithmetic.
module tb_a78_game_loader;
  localparam int MAXS      = 2;
  localparam int IMG_BYTES = MAXS * 512;

  logic        clk = 1'b0;
  logic        reset_i, start_i, sd_ready_i, sd_byte_available_i, psram_busy_i;
  logic [31:0] start_sector_i;
  logic [7:0]  sd_dout_i;
  logic        sd_rd_o, psram_write_req_o, loader_busy_o, game_loaded_o, error_o;
  logic [31:0] sd_address_o;
  logic [21:0] psram_addr_o;
  logic [7:0]  psram_wdata_o;

  always #5 clk = ~clk;

  a78_game_loader #(.MAX_SECTORS(MAXS)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .start_sector_i(start_sector_i),
    .sd_ready_i(sd_ready_i), .sd_rd_o(sd_rd_o), .sd_address_o(sd_address_o),
    .sd_dout_i(sd_dout_i), .sd_byte_available_i(sd_byte_available_i),
    .psram_write_req_o(psram_write_req_o), .psram_addr_o(psram_addr_o),
    .psram_wdata_o(psram_wdata_o), .psram_busy_i(psram_busy_i),
    .loader_busy_o(loader_busy_o), .game_loaded_o(game_loaded_o), .error_o(error_o)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  img [0:IMG_BYTES-1];
  logic [23:0] exp_q [$];
  int          n_exp = 0;
  int          writes_seen = 0;
  int          sd_rd_cnt = 0;
  int          payload_sent = 0;
  int          hold_next = 0;
  bit          throttle_en = 1'b1;
  bit          sd_abort = 1'b0;
  bit          sd_idle = 1'b1;
  logic [31:0] cur_start = 32'd0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic int pending();
    int p;
    p = (payload_sent < n_exp) ? payload_sent : n_exp;
    return p - writes_seen;
  endfunction

  // Reference model: image bytes plus the expected PSRAM writes derived from the header rules.
  task automatic build_image(input logic [31:0] size, input bit bad_hdr);
    logic [71:0] sigv;
    int n;
    sigv = "ATARI7800";
    for (int i = 0; i < IMG_BYTES; i++) img[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) img[1+i] = sigv[8*(8-i) +: 8];
    if (bad_hdr) img[1] = "B";
    img[49] = size[31:24];
    img[50] = size[23:16];
    img[51] = size[15:8];
    img[52] = size[7:0];
    exp_q.delete();
    n_exp = 0;
    if (!bad_hdr && size >= 32'd1 && size <= 32'd49152) begin
      n = (size > 32'(IMG_BYTES - 128)) ? IMG_BYTES - 128 : int'(size);
      for (int i = 0; i < n; i++)
        exp_q.push_back({16'(32'h10000 - size + 32'(i)), img[128+i]});
      n_exp = n;
    end
  endtask

  // SD controller model: answers each sd_rd with 512 bytes, one rising edge per byte.
  logic [31:0] sd_a;
  int          sd_sec, sd_off;
  initial begin
    sd_ready_i = 1'b1;
    sd_byte_available_i = 1'b0;
    sd_dout_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (sd_rd_o && sd_ready_i && !sd_abort) begin
        sd_a = sd_address_o;
        check("sd_address", sd_a, cur_start + 32'(sd_rd_cnt));
        sd_rd_cnt++;
        sd_sec = int'(sd_a - cur_start);
        sd_idle = 1'b0;
        sd_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int b = 0; b < 512 && !sd_abort; b++) begin
          sd_off = sd_sec * 512 + b;
          if (throttle_en)
            for (int w = 0; w < 300 && pending() >= 6; w++) begin
              @(posedge clk); #1;
            end
          sd_dout_i = (sd_off >= 0 && sd_off < IMG_BYTES) ? img[sd_off] : 8'h00;
          sd_byte_available_i = 1'b1;
          if (sd_off >= 128) payload_sent++;
          @(posedge clk); #1;
          sd_byte_available_i = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        sd_ready_i = 1'b1;
        sd_idle = 1'b1;
      end
    end
  end

  // PSRAM model and scoreboard monitor: every request is popped against the expected queue.
  logic [23:0] mon_e;
  int          mon_h;
  initial begin
    psram_busy_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (psram_write_req_o) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL psram_write: unexpected write addr %h data %h, expected none",
                   psram_addr_o, psram_wdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("psram_write", {psram_addr_o, psram_wdata_o}, {6'b0, mon_e});
        end
        psram_busy_i = 1'b1;
        mon_h = (hold_next > 0) ? hold_next : $urandom_range(4, 5);
        hold_next = 0;
        repeat (mon_h) @(posedge clk);
        #1 psram_busy_i = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] sec);
    start_sector_i = sec;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    start_sector_i = $urandom;
  endtask

  task automatic wait_quiet();
    int c;
    c = 0;
    while ((!sd_idle || psram_busy_i) && c < 8000) begin @(posedge clk); #1; c++; end
    check("quiet_timeout", 64'(c < 8000), 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_load(input string name, input logic [31:0] size, input bit bad_hdr,
                          input int hold_first, input bit exp_ok, input int exp_sectors,
                          input bit prefix, input bit restart_mid);
    int c;
    build_image(size, bad_hdr);
    cur_start = $urandom;
    writes_seen = 0;
    sd_rd_cnt = 0;
    payload_sent = 0;
    hold_next = hold_first;
    throttle_en = (hold_first == 0);
    pulse_start(cur_start);
    check({name, "/busy_rise"}, 64'(loader_busy_o), 64'd1);
    if (restart_mid) begin
      repeat (40) @(posedge clk);
      #1;
      pulse_start($urandom);
    end
    c = 0;
    while (loader_busy_o && c < 30000) begin @(posedge clk); #1; c++; end
    check({name, "/busy_fall"}, 64'(c < 30000), 64'd1);
    check({name, "/game_loaded"}, 64'(game_loaded_o), 64'(exp_ok));
    check({name, "/error"}, 64'(error_o), 64'(!exp_ok));
    check({name, "/sectors"}, 64'(sd_rd_cnt), 64'(exp_sectors));
    if (prefix) begin
      check({name, "/partial_writes"}, 64'(writes_seen < n_exp), 64'd1);
    end else begin
      check({name, "/writes"}, 64'(writes_seen), 64'(n_exp));
      check({name, "/left"}, 64'(exp_q.size()), 64'd0);
    end
    wait_quiet();
    exp_q.delete();
    n_exp = 0;
  endtask

  initial begin
    int sz, c;
    reset_i = 1'b1;
    start_i = 1'b0;
    start_sector_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", {sd_rd_o, psram_write_req_o, loader_busy_o, game_loaded_o, error_o}, 64'd0);
    check("reset_bus", {sd_address_o, psram_addr_o, psram_wdata_o}, 64'd0);
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_load("size1",   32'd1,   1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
    run_load("size384", 32'd384, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
    sz = $urandom_range(385, 896);
    run_load("sizemid", 32'(sz), 1'b0, 0, 1'b1, (128 + sz + 511) / 512, 1'b0, 1'b1);
    run_load("fill_all", 32'd896, 1'b0, 0, 1'b1, MAXS, 1'b0, 1'b0);
    run_load("sector_limit", 32'd897, 1'b0, 0, 1'b0, MAXS, 1'b1, 1'b0);
    run_load("bad_sig",  32'd300, 1'b1, 0, 1'b0, 1, 1'b0, 1'b0);
    run_load("size0",    32'd0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0);
    run_load("sizeC001", 32'h0000C001, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0);
    run_load("size_hi",  32'h00010040, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0);
    run_load("overflow", 32'd600, 1'b0, 5000, 1'b0, 1, 1'b1, 1'b0);

    // Reset in the middle of the second sector, then a clean reload.
    build_image(32'd700, 1'b0);
    cur_start = $urandom;
    writes_seen = 0;
    sd_rd_cnt = 0;
    payload_sent = 0;
    throttle_en = 1'b1;
    pulse_start(cur_start);
    c = 0;
    while (!(sd_rd_cnt >= 2 && payload_sent >= 600) && c < 20000) begin @(posedge clk); #1; c++; end
    check("reset_reach_sector1", 64'(c < 20000), 64'd1);
    #2;
    reset_i = 1'b1;
    sd_abort = 1'b1;
    #1;
    check("midreset_ctl", {sd_rd_o, psram_write_req_o, loader_busy_o, game_loaded_o, error_o}, 64'd0);
    check("midreset_bus", {sd_address_o, psram_addr_o, psram_wdata_o}, 64'd0);
    exp_q.delete();
    n_exp = 0;
    @(posedge clk); #1;
    wait_quiet();
    reset_i = 1'b0;
    sd_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sz = $urandom_range(200, 400);
    run_load("reload", 32'(sz), 1'b0, 0, 1'b1, 2 - ((128 + sz) <= 512 ? 1 : 0), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
